// File: rtl/adler32_checker_pkg.sv
// Shared definitions for the Adler-32 checker and generator slice.
//   MOD_ADLER      : Adler-32 modulus (largest prime below 2^16)
//   EMPTY_CHECKSUM : checksum of a zero-length message ({B=0, A=1})
//   state_t        : checker control states
package adler32_checker_pkg;

  localparam int unsigned MOD_ADLER      = 65521;
  localparam logic [31:0] EMPTY_CHECKSUM = 32'h0000_0001;

  typedef enum logic [2:0] {
    IDLE,
    SIZED,
    DATA,
    WAIT_CHK,
    REPORT
  } state_t;

endpackage

// File: rtl/adler32_accum.sv
// Adler-32 running-sum datapath: holds A and B and applies one byte per
// enabled cycle.
//   clk      : clock, state on rising edge
//   rst_n    : asynchronous active-low reset (A=1, B=0)
//   init     : restart the sums for a new message (A=1, B=0)
//   en       : accumulate data this cycle
//   data     : message byte
//   sum_next : {B, A} as it will be after accumulating data this cycle
module adler32_accum #(
  parameter int unsigned MOD_ADLER = adler32_checker_pkg::MOD_ADLER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] sum_next
);

  localparam logic [16:0] MOD17 = 17'(MOD_ADLER);

  logic [15:0] a;
  logic [15:0] b;
  logic [16:0] a_sum;
  logic [16:0] b_sum;
  logic [15:0] a_next;
  logic [15:0] b_next;

  // Both operands are already reduced, so one conditional subtract suffices:
  // A+data < MOD+256 and B+A < 2*MOD both fit in 17 bits.
  always_comb begin
    a_sum    = {1'b0, a} + {9'b0, data};
    a_next   = 16'((a_sum >= MOD17) ? (a_sum - MOD17) : a_sum);
    b_sum    = {1'b0, b} + {1'b0, a_next};
    b_next   = 16'((b_sum >= MOD17) ? (b_sum - MOD17) : b_sum);
    sum_next = {b_next, a_next};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= 16'd1;
      b <= '0;
    end else if (init) begin
      a <= 16'd1;
      b <= '0;
    end else if (en) begin
      a <= a_next;
      b <= b_next;
    end
  end

endmodule

// File: rtl/adler32_checker.sv
// Adler-32 message checker: captures a byte count, accumulates that many
// bytes, then compares the result against a supplied expected checksum.
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   size_valid   : capture size (IDLE, or re-capture in SIZED)
//   size         : message length in bytes
//   data_start   : open the data phase (SIZED only)
//   data_valid   : qualifies data (DATA only)
//   data         : message byte
//   chk_valid    : expected checksum strobe (WAIT_CHK only)
//   chk          : expected checksum {B, A}
//   busy         : high whenever not IDLE
//   result_valid : one-cycle verdict pulse
//   match        : verdict, meaningful with result_valid
//   computed     : locally computed checksum, held until overwritten
module adler32_checker #(
  parameter int unsigned SIZE_W    = 32,
  parameter int unsigned MOD_ADLER = adler32_checker_pkg::MOD_ADLER
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              size_valid,
  input  logic [SIZE_W-1:0] size,
  input  logic              data_start,
  input  logic              data_valid,
  input  logic [7:0]        data,
  input  logic              chk_valid,
  input  logic [31:0]       chk,
  output logic              busy,
  output logic              result_valid,
  output logic              match,
  output logic [31:0]       computed
);

  import adler32_checker_pkg::*;

  state_t            state;
  state_t            state_next;
  logic [SIZE_W-1:0] count;
  logic [31:0]       sum_next;
  logic              acc_init;
  logic              acc_en;
  logic              cnt_load;
  logic              cnt_dec;
  logic              comp_load_sum;
  logic              comp_load_empty;
  logic              match_load;

  adler32_accum #(
    .MOD_ADLER (MOD_ADLER)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (acc_init),
    .en       (acc_en),
    .data     (data),
    .sum_next (sum_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    acc_init        = 1'b0;
    acc_en          = 1'b0;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    comp_load_sum   = 1'b0;
    comp_load_empty = 1'b0;
    match_load      = 1'b0;
    case (state)
      IDLE: begin
        if (size_valid) begin
          cnt_load   = 1'b1;
          acc_init   = 1'b1;
          state_next = SIZED;
        end
      end
      SIZED: begin
        // data_start wins over a same-cycle size re-capture
        if (data_start) begin
          if (count == '0) begin
            comp_load_empty = 1'b1;
            state_next      = WAIT_CHK;
          end else begin
            state_next = DATA;
          end
        end else if (size_valid) begin
          cnt_load = 1'b1;
        end
      end
      DATA: begin
        if (data_valid) begin
          acc_en  = 1'b1;
          cnt_dec = 1'b1;
          if (count == SIZE_W'(1)) begin
            comp_load_sum = 1'b1;
            state_next    = WAIT_CHK;
          end
        end
      end
      WAIT_CHK: begin
        if (chk_valid) begin
          match_load = 1'b1;
          state_next = REPORT;
        end
      end
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // computed is captured from the accumulator's next value so it is valid
  // the cycle right after the final byte is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      computed <= '0;
      match    <= 1'b0;
    end else begin
      if (cnt_load)     count <= size;
      else if (cnt_dec) count <= count - SIZE_W'(1);
      if (comp_load_empty)    computed <= EMPTY_CHECKSUM;
      else if (comp_load_sum) computed <= sum_next;
      if (match_load) match <= (chk == computed);
    end
  end

  assign busy         = (state != IDLE);
  assign result_valid = (state == REPORT);

endmodule
